// File: rtl/vga_sample_arbiter.sv
// Arbitrates a single-port sine-sample RAM: pixel reads (absolute priority) vs. sample writes.
// Read: request t -> ram_en t+1 -> pix_sample/pix_valid t+3; write: grant t -> ram_we/wr_ack t+1.
module vga_sample_arbiter #(
    parameter int DEPTH      = 640,
    parameter int H_OFFSET   = 144,
    parameter int BLANK_ONLY = 1,
    parameter int MAX_WAIT   = 1023
) (
    input  logic       i_mclk,
    input  logic       i_start,
    input  logic       i_pix_en,
    input  logic       i_vidon,
    input  logic [9:0] i_hc,
    input  logic       i_wr_req,
    input  logic [9:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    output logic       o_wr_ack,
    output logic       o_wr_err,
    output logic       o_wr_stall,
    output logic       o_ram_en,
    output logic       o_ram_we,
    output logic [9:0] o_ram_addr,
    output logic [7:0] o_ram_wdata,
    input  logic [7:0] i_ram_rdata,
    output logic [7:0] o_pix_sample,
    output logic       o_pix_valid
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t      r_state;
    logic        r_rd1_zero;
    logic        r_rd2_vld;
    logic        r_rd2_zero;
    logic [9:0]  r_wait;

    logic        w_rq_rd;
    logic        w_rq_wr;
    logic        w_grant;
    logic [10:0] w_hc_rel;
    logic        w_rd_ok;
    logic        w_wr_ok;
    logic [9:0]  w_wait_nxt;

    assign w_rq_rd  = i_pix_en & i_vidon;
    assign w_rq_wr  = i_wr_req & ~o_wr_ack & ((BLANK_ONLY == 0) | ~i_vidon);
    assign w_grant  = w_rq_wr & ~w_rq_rd;
    assign w_hc_rel = {1'b0, i_hc} - 11'(H_OFFSET);
    assign w_rd_ok  = (i_hc >= 10'(H_OFFSET)) && (w_hc_rel < 11'(DEPTH));
    assign w_wr_ok  = {1'b0, i_wr_addr} < 11'(DEPTH);

    always_comb begin
        w_wait_nxt = r_wait;
        if (!i_wr_req || w_grant)
            w_wait_nxt = 10'd0;
        else if (r_wait != 10'h3FF)
            w_wait_nxt = r_wait + 10'd1;
    end

    always_ff @(posedge i_mclk) begin
        if (i_start) begin
            r_state      <= IDLE;
            r_rd1_zero   <= 1'b0;
            r_rd2_vld    <= 1'b0;
            r_rd2_zero   <= 1'b0;
            r_wait       <= 10'd0;
            o_wr_ack     <= 1'b0;
            o_wr_err     <= 1'b0;
            o_wr_stall   <= 1'b0;
            o_ram_en     <= 1'b0;
            o_ram_we     <= 1'b0;
            o_ram_addr   <= 10'd0;
            o_ram_wdata  <= 8'd0;
            o_pix_sample <= 8'd0;
            o_pix_valid  <= 1'b0;
        end else begin
            o_wr_ack <= 1'b0;
            o_ram_en <= 1'b0;
            o_ram_we <= 1'b0;
            if (w_rq_rd) begin
                // out-of-range columns still occupy a pipeline slot as a zero sample
                r_state    <= RD;
                o_ram_en   <= w_rd_ok;
                o_ram_addr <= w_hc_rel[9:0];
                r_rd1_zero <= ~w_rd_ok;
            end else if (w_rq_wr) begin
                r_state     <= WR;
                o_ram_en    <= w_wr_ok;
                o_ram_we    <= w_wr_ok;
                o_ram_addr  <= i_wr_addr;
                o_ram_wdata <= i_wr_data;
                o_wr_ack    <= 1'b1;
                if (!w_wr_ok)
                    o_wr_err <= 1'b1;
            end else begin
                r_state <= IDLE;
            end

            r_rd2_vld   <= (r_state == RD);
            r_rd2_zero  <= r_rd1_zero;
            o_pix_valid <= r_rd2_vld;
            if (r_rd2_vld)
                o_pix_sample <= r_rd2_zero ? 8'd0 : i_ram_rdata;

            r_wait <= w_wait_nxt;
            if (w_wait_nxt > 10'(MAX_WAIT))
                o_wr_stall <= 1'b1;
        end
    end

endmodule

// File: doc/vga_sample_arbiter.md
Name: vga_sample_arbiter

Overview:
- Shares one single-port sample RAM (one 8-bit sine sample per screen column) between two requesters.
- Requester 1 is the VGA pixel path: a read is issued for every active pixel and has absolute priority.
- Requester 2 is the sine-wave sample writer, which gets only the cycles the pixel path leaves free.
- Sits between the VGA timing generator (pix_en, hc, vidon) and the plot/colour logic.

Parameters:
- DEPTH, 640, number of RAM words; valid addresses are 0..DEPTH-1.
- H_OFFSET, 144, hc value mapped to RAM address 0 (read address = hc - H_OFFSET).
- BLANK_ONLY, 1, 1 = writes granted only while vidon==0; 0 = writes granted in any free cycle.
- MAX_WAIT, 1023, number of wr_req cycles without a grant before wr_stall sets (10-bit compare).

Ports:
- mclk  in  1  system clock (50 MHz).
- start  in  1  synchronous active-high reset.
- pix_en  in  1  one-mclk strobe per pixel (every 2nd mclk).
- vidon  in  1  active-video flag from the timing generator.
- hc  in  10  horizontal pixel counter.
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_ack.
- wr_addr  in  10  write address.
- wr_data  in  8  write sample.
- wr_ack  out  1  one-cycle pulse when the write is committed or dropped.
- wr_err  out  1  sticky: an out-of-range write was dropped.
- wr_stall  out  1  sticky: writer waited more than MAX_WAIT cycles.
- ram_en  out  1  RAM enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  10  RAM address (registered).
- ram_wdata  out  8  RAM write data (registered).
- ram_rdata  in  8  RAM read data, valid one cycle after ram_en with ram_we==0.
- pix_sample  out  8  sample for the current column.
- pix_valid  out  1  one-cycle pulse when pix_sample is updated.

Behaviour:
- Reset (start==1 at a mclk edge):
  - All outputs go to 0: wr_ack, wr_err, wr_stall, ram_*, pix_sample, pix_valid.
  - Read pipeline is flushed; the wait counter clears; the FSM goes to IDLE.
  - Any in-flight read produces no pix_valid.
  - A writer request held through reset is re-arbitrated from scratch after reset; it is never acked for the pre-reset cycle.
- FSM has three states, each lasting one cycle; each state describes what the registered ram_* outputs drive that cycle. The next state is decided every cycle from the current-cycle inputs:
  - Read request rq_rd = pix_en & vidon.
  - Write request rq_wr = wr_req & ~wr_ack & (BLANK_ONLY==0 | ~vidon).
  - If rq_rd, next state is RD.
  - Else if rq_wr, next state is WR.
  - Else next state is IDLE.
- Read always wins over write on a simultaneous request; the write waits.
- IDLE: ram_en=0, ram_we=0.
- RD: ram_en=1, ram_we=0, ram_addr = (hc - H_OFFSET) computed in 10 bits from the request cycle.
  - If hc < H_OFFSET or hc - H_OFFSET >= DEPTH, the read is suppressed (ram_en=0), but the pipeline still tracks it as a zero sample.
- Read latency: request cycle t, ram_en in t+1, ram_rdata valid in t+2, pix_sample/pix_valid updated in t+3.
  - A suppressed read gives pix_sample=0 with pix_valid=1 in t+3.
  - Reads are pipelined: one per pix_en, with no bubbles.
- WR: ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data (captured in the grant cycle t); wr_ack=1 in t+1.
  - If wr_addr >= DEPTH: ram_en=0 in t+1, wr_ack still pulses, wr_err sets.
- No grant is issued in a cycle where wr_ack==1. The requester updates wr_addr/wr_data or drops wr_req in that cycle, so there is at most one write per 2 cycles and no double commit.
- Wait counter:
  - Increments each cycle wr_req==1 and no grant is issued.
  - Clears on grant or when wr_req==0.
  - Saturates at 1023.
  - wr_stall sets when the counter exceeds MAX_WAIT.
- wr_err and wr_stall clear only on start.
- While vidon==1 and BLANK_ONLY==1, writes are never granted; pending requests wait for blanking.
- hc wrap (799 -> 0) needs no special handling; the range check covers it.

Test Plan:
- Reset then idle: hold start=1 for 3 cycles, then no requests -> every output 0; ram_en stays 0 for 100 cycles.
- Active line read: vidon=1, pix_en every 2nd cycle, hc=144..147, RAM word0..3 = 0x10,0x20,0x30,0x40 -> ram_addr 0..3 in request+1 cycles; pix_sample 0x10..0x40 with pix_valid exactly 3 cycles after each pix_en.
- Out-of-range read: hc=100 and hc=784 with vidon=1 -> ram_en=0, pix_sample=0, pix_valid=1 at t+3.
- Blanking write with BLANK_ONLY=1: vidon=0, wr_req with addr=5, data=0xA5 -> ram_we=1, ram_addr=5, ram_wdata=0xA5 in t+1; wr_ack in t+1. A back-to-back second request commits no earlier than t+3.
- Collision with BLANK_ONLY=0, vidon=1: wr_req asserted in the same cycle as pix_en -> read issued first; write granted the next cycle (t+1), committed in t+2; wr_ack in t+2.
- Error and stall:
  - wr_addr=700 -> acked, ram_en=0, wr_err=1 until start.
  - With BLANK_ONLY=1, MAX_WAIT=15, vidon=1 held and wr_req held 20 cycles -> wr_stall=1 from cycle 17. wr_req must remain ungranted throughout.
- Mid-read reset: pix_en at t, start=1 at t+1 -> no pix_valid at t+3; all outputs 0 at t+2.
